// File: rtl/serpack_pkg.sv
// -----------------------------------------------------------------------------
// serpack_pkg
//   Shared definitions for the serial length packer:
//     - FSM state encodings (legacy constants) and the matching state enum
//     - pointer / occupancy width helpers for the result FIFO
//     - sig_len(): minimal frame length of a result word
//   No ports (package).
// -----------------------------------------------------------------------------
package serpack_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LEN  = 2'd1;
    localparam logic [1:0] ST_VAL  = 2'd2;
    localparam logic [1:0] ST_PAR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LEN  = ST_LEN,
        S_VAL  = ST_VAL,
        S_PAR  = ST_PAR
    } state_e;

    // Widest result word sig_len() can measure.
    localparam int unsigned SIG_MAX_W = 128;
    typedef logic [SIG_MAX_W-1:0] sig_val_t;

    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy-style counters must be able to hold the value DEPTH itself.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Minimal number of value bits needed to represent the low 'width' bits of
    // 'value'. Unsigned: position of the highest 1 plus one. Signed: width
    // minus redundant sign bits. Either way the result is at least 1.
    function automatic int unsigned sig_len(input sig_val_t    value,
                                            input int unsigned width,
                                            input logic        signed_mode);
        int unsigned len;
        sig_val_t    sh;
        logic        sign;
        len  = 1;
        sh   = value >> (width - 1);
        sign = signed_mode & sh[0];
        sh   = value;
        for (int unsigned i = 0; i < SIG_MAX_W; i++) begin
            if (signed_mode) begin
                if ((i + 1 < width) && (sh[0] != sign)) len = i + 2;
            end else begin
                if ((i < width) && sh[0]) len = i + 1;
            end
            sh = sh >> 1;
        end
        return len;
    endfunction

endpackage

// File: rtl/serial_len_packer_if.sv
// -----------------------------------------------------------------------------
// serial_len_packer_if
//   Groups the result-input handshake and the serial output of the packer.
//     in_valid/in_ready/in_value/in_last : result word push handshake
//     out_valid/out_value                : serial frame bit stream
//   master: the producer/consumer side (core + pads); slave: the packer.
// -----------------------------------------------------------------------------
interface serial_len_packer_if #(
    parameter int unsigned VAL_W = 40
);
    logic             in_valid;
    logic             in_ready;
    logic [VAL_W-1:0] in_value;
    logic             in_last;
    logic             out_valid;
    logic             out_value;

    modport master (
        output in_valid, in_value, in_last,
        input  in_ready, out_valid, out_value
    );

    modport slave (
        input  in_valid, in_value, in_last,
        output in_ready, out_valid, out_value
    );
endinterface

// File: rtl/serpack_fifo.sv
// -----------------------------------------------------------------------------
// serpack_fifo
//   Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
//     clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//     push_i       : write push_data_i when not full
//     push_data_i  : write data
//     pop_i        : discard head entry when not empty
//     pop_data_o   : current head entry (valid while !empty_o)
//     full_o       : no free entry
//     empty_o      : no stored entry
// -----------------------------------------------------------------------------
module serpack_fifo
    import serpack_pkg::*;
#(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/serial_len_packer.sv
// -----------------------------------------------------------------------------
// serial_len_packer
//   Buffers result words and sends them as variable-length serial frames:
//   LEN_W-bit length L (MSB first) then the low L value bits (MSB first).
//   Frames of one burst are sent back-to-back; a burst starts when a word
//   carrying in_last is buffered (or the FIFO is full) and hold is low.
//   Optional build macro SERPACK_PARITY_EN: appends one even-parity bit over
//   the length and value bits of every frame.
//     clk, rst   : clock, synchronous active-high reset
//     cfg_signed : 1 = two's-complement minimal length, 0 = unsigned length
//     hold       : blocks the start of a new burst
//     bus        : in_valid/in_ready/in_value/in_last, out_valid/out_value
//     busy       : FIFO non-empty or a burst in progress
//     underrun   : sticky, FIFO ran dry mid-burst before the last word
// -----------------------------------------------------------------------------
module serial_len_packer
    import serpack_pkg::*;
#(
    parameter int unsigned VAL_W = 40,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_signed,
    input  logic                hold,
    serial_len_packer_if.slave  bus,
    output logic                busy,
    output logic                underrun
);
    localparam int unsigned CNT_W = fifo_cnt_w(DEPTH);

    if (((64'd1 << LEN_W) - 64'd1) < 64'(VAL_W)) begin : g_len_w_chk
        $error("serial_len_packer: LEN_W cannot encode a length of VAL_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("serial_len_packer: DEPTH must be a power of 2 and >= 2");
    end
    if (VAL_W > SIG_MAX_W) begin : g_val_w_chk
        $error("serial_len_packer: VAL_W exceeds SIG_MAX_W");
    end

    state_e           state_q,     state_d;
    logic [LEN_W-1:0] len_q,       len_d;
    logic [LEN_W-1:0] len_sh_q,    len_sh_d;
    logic [LEN_W-1:0] cnt_q,       cnt_d;
    logic [VAL_W-1:0] val_sh_q,    val_sh_d;
    logic             last_q,      last_d;
    logic             par_q,       par_d;
    logic             out_valid_q, out_valid_d;
    logic             out_value_q, out_value_d;
    logic             underrun_q,  underrun_d;
    logic [CNT_W-1:0] last_cnt_q,  last_cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             push_ok;
    logic [VAL_W:0]   fifo_head;
    logic [LEN_W-1:0] head_len;
    logic [VAL_W-1:0] head_aligned;
    logic             start_ok;
    logic             frame_done;
    logic             load;
    logic             bit_d;

    serpack_fifo #(
        .WIDTH (VAL_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.in_valid),
        .push_data_i ({bus.in_last, bus.in_value}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign push_ok = bus.in_valid && !fifo_full;

    // Length is taken from the head word at pop time, so cfg_signed only
    // matters at the instant a word leaves the FIFO.
    assign head_len     = LEN_W'(sig_len(sig_val_t'(fifo_head[VAL_W-1:0]), VAL_W, cfg_signed));
    // Left-align the L value bits so the value phase always shifts out the MSB.
    assign head_aligned = fifo_head[VAL_W-1:0] << (VAL_W - int'(head_len));

    assign start_ok = (state_q == S_IDLE) && !hold &&
                      ((last_cnt_q != '0) || fifo_full);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        len_sh_d    = len_sh_q;
        cnt_d       = cnt_q;
        val_sh_d    = val_sh_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        underrun_d  = underrun_q;
        fifo_pop    = 1'b0;
        frame_done  = 1'b0;
        load        = 1'b0;
        bit_d       = 1'b0;

        // cnt_q counts the bits of the current field still to come after the
        // one presently on out_value.
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) load = 1'b1;
            end
            S_LEN: begin
                if (cnt_q != '0) begin
                    bit_d    = len_sh_q[LEN_W-1];
                    len_sh_d = len_sh_q << 1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    state_d  = S_VAL;
                    bit_d    = val_sh_q[VAL_W-1];
                    val_sh_d = val_sh_q << 1;
                    cnt_d    = len_q - 1'b1;
                end
            end
            S_VAL: begin
                if (cnt_q != '0) begin
                    bit_d    = val_sh_q[VAL_W-1];
                    val_sh_d = val_sh_q << 1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
`ifdef SERPACK_PARITY_EN
                    state_d = S_PAR;
                    bit_d   = par_q;
`else
                    frame_done = 1'b1;
`endif
                end
            end
            S_PAR: begin
                frame_done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (frame_done) begin
            if (last_q) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end else if (!fifo_empty) begin
                load = 1'b1;
            end else begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                underrun_d  = 1'b1;
            end
        end

        if (load) begin
            fifo_pop    = 1'b1;
            state_d     = S_LEN;
            len_d       = head_len;
            bit_d       = head_len[LEN_W-1];
            len_sh_d    = head_len << 1;
            cnt_d       = LEN_W'(LEN_W - 1);
            val_sh_d    = head_aligned;
            last_d      = fifo_head[VAL_W];
            out_valid_d = 1'b1;
        end

        out_value_d = out_valid_d & bit_d;
        // Running parity includes the bit now being emitted; a fresh frame restarts it.
        par_d       = load ? bit_d : (par_q ^ bit_d);
    end

    always_comb begin
        last_cnt_d = last_cnt_q;
        if ((push_ok && bus.in_last) && !(fifo_pop && fifo_head[VAL_W])) begin
            last_cnt_d = last_cnt_q + 1'b1;
        end else if (!(push_ok && bus.in_last) && (fifo_pop && fifo_head[VAL_W])) begin
            last_cnt_d = last_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            len_sh_q    <= '0;
            cnt_q       <= '0;
            val_sh_q    <= '0;
            last_q      <= 1'b0;
            par_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= 1'b0;
            underrun_q  <= 1'b0;
            last_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            len_sh_q    <= len_sh_d;
            cnt_q       <= cnt_d;
            val_sh_q    <= val_sh_d;
            last_q      <= last_d;
            par_q       <= par_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            underrun_q  <= underrun_d;
            last_cnt_q  <= last_cnt_d;
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
    assign busy          = !fifo_empty || (state_q != S_IDLE);
    assign underrun      = underrun_q;
endmodule

// File: tb/tb_serial_len_packer.sv
`timescale 1ns/1ps
module tb_serial_len_packer;
    localparam int unsigned VAL_W = 40;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned DEPTH = 16;
`ifdef SERPACK_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic cfg_signed;
    logic hold;
    logic busy;
    logic underrun;

    serial_len_packer_if #(.VAL_W(VAL_W)) bus ();

    serial_len_packer #(
        .VAL_W (VAL_W),
        .LEN_W (LEN_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_signed (cfg_signed),
        .hold       (hold),
        .bus        (bus),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    bit exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [VAL_W-1:0] v;
        logic             s;
        int               len;
    } vec_t;

    // value, signed mode, hand-derived minimal length
    vec_t tab[10] = '{
        '{40'd5,            1'b0, 3},
        '{40'hFF_FFFF_FFFD, 1'b1, 3},
        '{40'd0,            1'b0, 1},
        '{40'd0,            1'b1, 1},
        '{40'hFF_FFFF_FFFF, 1'b1, 1},
        '{40'd5,            1'b1, 4},
        '{40'hFF_FFFF_FFFF, 1'b0, 40},
        '{40'h80_0000_0000, 1'b1, 40},
        '{40'h7F_FFFF_FFFF, 1'b1, 40},
        '{40'hFF_FFFF_FF80, 1'b1, 8}
    };

    // Serial monitor: every valid bit is popped from the expected stream.
    always @(negedge clk) begin
        bit e;
        if (mon_en) begin
            if (bus.out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL serial_bit: got %b with nothing expected at %0t", bus.out_value, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_value !== e) begin
                        n_err++;
                        $display("FAIL serial_bit: got %b want %b at %0t", bus.out_value, e, $time);
                    end
                end
            end else begin
                n_cmp++;
                if (bus.out_value !== 1'b0 || bus.out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_out: out_valid=%b out_value=%b want 0/0 at %0t",
                             bus.out_valid, bus.out_value, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic expect_frame(input int len, input logic [VAL_W-1:0] v);
        logic [LEN_W-1:0] lf;
        bit p;
        lf = LEN_W'(len);
        p  = 1'b0;
        for (int i = LEN_W - 1; i >= 0; i--) begin
            exp_q.push_back(lf[i]);
            p ^= lf[i];
        end
        for (int i = len - 1; i >= 0; i--) begin
            exp_q.push_back(v[i]);
            p ^= v[i];
        end
        if (PAR_BITS != 0) exp_q.push_back(p);
    endtask

    // Called at posedge+1; returns at posedge+1 after the push edge.
    task automatic push_word(input logic [VAL_W-1:0] v, input logic last,
                             input int len, input bit want_acc);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_last  = last;
        @(negedge clk);
        acc = bus.in_ready;
        check("in_ready", {63'd0, acc}, {63'd0, want_acc});
        if (want_acc) expect_frame(len, v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Measures negedges until out_valid rises and the length of the valid run.
    task automatic measure(output int lat, output int run, input int hold_at);
        lat = 0;
        run = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 60);
        if (bus.out_valid !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_timeout: out_valid never rose within %0d cycles", lat);
        end else begin
            run = 1;
            while (run < 2000) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1) break;
                run++;
                if (run == hold_at) hold = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || bus.out_valid !== 1'b0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("idle_timeout", {63'd0, (n >= budget)}, 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int run;
        rst          = 1'b1;
        cfg_signed   = 1'b0;
        hold         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_value", {63'd0, bus.out_value}, 64'd0);
        check("rst_busy",      {63'd0, busy},          64'd0);
        check("rst_underrun",  {63'd0, underrun},      64'd0);
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single-word bursts, unsigned and signed lengths, boundaries.
        foreach (tab[k]) begin
            cfg_signed = tab[k].s;
            push_word(tab[k].v, 1'b1, tab[k].len, 1'b1);
            measure(lat, run, -1);
            check("single_latency", 64'(lat), 64'd2);
            check("single_run", 64'(run), 64'(LEN_W + tab[k].len + PAR_BITS));
            wait_idle(20);
        end
        cfg_signed = 1'b0;

        // Burst held back by hold, then released; hold raised mid-burst is ignored.
        hold = 1'b1;
        push_word(40'd7,   1'b0, 3, 1'b1);
        push_word(40'd1,   1'b0, 1, 1'b1);
        push_word(40'd255, 1'b1, 8, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("hold_gates_start", {63'd0, bus.out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        measure(lat, run, 5);
        check("burst_latency", 64'(lat), 64'd2);
        check("burst_run", 64'(run), 64'(30 + 3 * PAR_BITS));
        hold = 1'b0;
        wait_idle(20);
        check("no_underrun_after_last", {63'd0, underrun}, 64'd0);

        // Fill the FIFO without in_last: force-start, then underrun.
        push_word(40'd1,  1'b0, 1, 1'b1);
        push_word(40'd2,  1'b0, 2, 1'b1);
        push_word(40'd3,  1'b0, 2, 1'b1);
        push_word(40'd4,  1'b0, 3, 1'b1);
        push_word(40'd5,  1'b0, 3, 1'b1);
        push_word(40'd6,  1'b0, 3, 1'b1);
        push_word(40'd7,  1'b0, 3, 1'b1);
        push_word(40'd8,  1'b0, 4, 1'b1);
        push_word(40'd9,  1'b0, 4, 1'b1);
        push_word(40'd10, 1'b0, 4, 1'b1);
        push_word(40'd11, 1'b0, 4, 1'b1);
        push_word(40'd12, 1'b0, 4, 1'b1);
        push_word(40'd13, 1'b0, 4, 1'b1);
        push_word(40'd14, 1'b0, 4, 1'b1);
        push_word(40'd15, 1'b0, 4, 1'b1);
        push_word(40'd16, 1'b0, 5, 1'b1);
        push_word(40'd99, 1'b0, 7, 1'b0);
        measure(lat, run, -1);
        check("full_start_latency", 64'(lat), 64'd1);
        check("full_run", 64'(run), 64'(150 + 16 * PAR_BITS));
        wait_idle(20);
        check("underrun_set",       {63'd0, underrun},      64'd1);
        check("underrun_out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Reset three bits into a frame with another word still buffered.
        push_word(40'd255, 1'b1, 8, 1'b1);
        push_word(40'd7,   1'b1, 3, 1'b1);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("pre_rst_started", {63'd0, bus.out_valid}, 64'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_out_value", {63'd0, bus.out_value}, 64'd0);
        check("rst_mid_busy",      {63'd0, busy},          64'd0);
        check("rst_mid_underrun",  {63'd0, underrun},      64'd0);
        check("rst_mid_in_ready",  {63'd0, bus.in_ready},  64'd1);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        push_word(40'd5, 1'b1, 3, 1'b1);
        measure(lat, run, -1);
        check("post_rst_latency", 64'(lat), 64'd2);
        check("post_rst_run", 64'(run), 64'(9 + PAR_BITS));
        wait_idle(20);

        check("expected_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
